// File: rtl/result_bus_arbiter_if.sv
// Result-producer to broadcast-bus interface: per-unit ready/valid results in,
// registered valid-only update bus out. Also defines the CR0/XER flag bundle.
typedef struct packed {
    logic [0:3] cr0;
    logic [0:2] xer;
} cond_exception_t;

interface result_bus_arbiter_if #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5
);
    logic [0:UNITS-1]                    unit_valid;
    logic [0:UNITS-1]                    unit_ready;
    logic [0:UNITS-1][0:RS_ID_WIDTH-1]   unit_rs_id;
    logic [0:UNITS-1][0:4]               unit_result_reg_addr;
    logic [0:UNITS-1][0:31]              unit_result;
    cond_exception_t [0:UNITS-1]         unit_cr0_xer;

    logic                                update_valid;
    logic [0:RS_ID_WIDTH-1]              update_rs_id;
    logic [0:4]                          update_result_reg_addr;
    logic [0:31]                         update_value;
    cond_exception_t                     update_cr0_xer;

    // Producer side: drives results and observes grants and the broadcast.
    modport master (
        output unit_valid, unit_rs_id, unit_result_reg_addr, unit_result, unit_cr0_xer,
        input  unit_ready,
        input  update_valid, update_rs_id, update_result_reg_addr, update_value, update_cr0_xer
    );

    modport slave (
        input  unit_valid, unit_rs_id, unit_result_reg_addr, unit_result, unit_cr0_xer,
        output unit_ready,
        output update_valid, update_rs_id, update_result_reg_addr, update_value, update_cr0_xer
    );
endinterface

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter granting one functional-unit result per cycle onto a registered
// valid-only broadcast bus. Define RESULT_BUS_PERF_EN to add broadcast/conflict counters.
module result_bus_arbiter #(
    parameter int UNITS       = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    result_bus_arbiter_if.slave  bus
`ifdef RESULT_BUS_PERF_EN
    ,
    output logic [0:31]          perf_broadcasts,
    output logic [0:31]          perf_conflicts
`endif
);
    localparam int PTR_W = $clog2(UNITS);

    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W:0]          cand;
    logic                    grant_found;
    logic                    transfer;
    logic [0:UNITS-1]        ready;

    logic                    update_valid_q, update_valid_d;
    logic [0:RS_ID_WIDTH-1]  update_rs_id_q, update_rs_id_d;
    logic [0:4]              update_reg_addr_q, update_reg_addr_d;
    logic [0:31]             update_value_q, update_value_d;
    cond_exception_t         update_flags_q, update_flags_d;

    // Search from ptr upward, folding the candidate back into 0..UNITS-1 so that
    // non-power-of-2 unit counts wrap correctly.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < UNITS; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(UNITS)) begin
                cand = cand - (PTR_W+1)'(UNITS);
            end
            if (!grant_found && bus.unit_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign transfer = grant_found & ~rst;

    always_comb begin
        ready = '0;
        if (transfer) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign bus.unit_ready = ready;

    always_comb begin
        ptr_d             = ptr_q;
        update_valid_d    = 1'b0;
        update_rs_id_d    = update_rs_id_q;
        update_reg_addr_d = update_reg_addr_q;
        update_value_d    = update_value_q;
        update_flags_d    = update_flags_q;
        if (transfer) begin
            ptr_d             = (grant_idx == PTR_W'(UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
            update_valid_d    = 1'b1;
            update_rs_id_d    = bus.unit_rs_id[grant_idx];
            update_reg_addr_d = bus.unit_result_reg_addr[grant_idx];
            update_value_d    = bus.unit_result[grant_idx];
            update_flags_d    = bus.unit_cr0_xer[grant_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q             <= '0;
            update_valid_q    <= 1'b0;
            update_rs_id_q    <= '0;
            update_reg_addr_q <= '0;
            update_value_q    <= '0;
            update_flags_q    <= '0;
        end else begin
            ptr_q             <= ptr_d;
            update_valid_q    <= update_valid_d;
            update_rs_id_q    <= update_rs_id_d;
            update_reg_addr_q <= update_reg_addr_d;
            update_value_q    <= update_value_d;
            update_flags_q    <= update_flags_d;
        end
    end

    assign bus.update_valid           = update_valid_q;
    assign bus.update_rs_id           = update_rs_id_q;
    assign bus.update_result_reg_addr = update_reg_addr_q;
    assign bus.update_value           = update_value_q;
    assign bus.update_cr0_xer         = update_flags_q;

`ifdef RESULT_BUS_PERF_EN
    logic [0:31] perf_broadcasts_q, perf_broadcasts_d;
    logic [0:31] perf_conflicts_q, perf_conflicts_d;

    always_comb begin
        perf_broadcasts_d = perf_broadcasts_q + (transfer ? 32'd1 : 32'd0);
        perf_conflicts_d  = perf_conflicts_q + (($countones(bus.unit_valid) >= 2) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_broadcasts_q <= '0;
            perf_conflicts_q  <= '0;
        end else begin
            perf_broadcasts_q <= perf_broadcasts_d;
            perf_conflicts_q  <= perf_conflicts_d;
        end
    end

    assign perf_broadcasts = perf_broadcasts_q;
    assign perf_conflicts  = perf_conflicts_q;
`endif

`ifndef SYNTHESIS
    // A unit that is waiting for its grant must keep presenting its result.
    for (genvar i = 0; i < UNITS; i++) begin : g_hold_chk
        assert property (@(posedge clk) disable iff (rst)
            (bus.unit_valid[i] && !bus.unit_ready[i]) |=> bus.unit_valid[i]);
    end
`endif
endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: directed grant vectors on a 4-unit and a
// 3-unit instance; a negedge monitor pops expected broadcasts as update_valid appears.
module tb_result_bus_arbiter;
    localparam int RSW = 5;

    typedef struct packed {
        logic [0:RSW-1]  rs_id;
        logic [0:4]      addr;
        logic [0:31]     value;
        cond_exception_t flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_bus_arbiter_if #(.UNITS(4), .RS_ID_WIDTH(RSW)) bus4 ();
    result_bus_arbiter_if #(.UNITS(3), .RS_ID_WIDTH(RSW)) bus3 ();

`ifdef RESULT_BUS_PERF_EN
    logic [0:31] perf_b4, perf_c4, perf_b3, perf_c3;
`endif

    result_bus_arbiter #(.UNITS(4), .RS_ID_WIDTH(RSW)) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
`ifdef RESULT_BUS_PERF_EN
        ,
        .perf_broadcasts(perf_b4),
        .perf_conflicts(perf_c4)
`endif
    );

    result_bus_arbiter #(.UNITS(3), .RS_ID_WIDTH(RSW)) dut3 (
        .clk(clk),
        .rst(rst),
        .bus(bus3)
`ifdef RESULT_BUS_PERF_EN
        ,
        .perf_broadcasts(perf_b3),
        .perf_conflicts(perf_c3)
`endif
    );

    int tests = 0;
    int fails = 0;
    exp_t q4[$];
    exp_t q3[$];
    exp_t dropped;

    logic [0:RSW-1]  rs_id_a [0:3];
    logic [0:4]      addr_a  [0:3];
    logic [0:31]     val_a   [0:3];
    cond_exception_t flags_a [0:3];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveUnits4(input logic [0:3] mask);
        for (int i = 0; i < 4; i++) begin
            bus4.unit_rs_id[i]           = rs_id_a[i];
            bus4.unit_result_reg_addr[i] = addr_a[i];
            bus4.unit_result[i]          = val_a[i];
            bus4.unit_cr0_xer[i]         = flags_a[i];
        end
        bus4.unit_valid = mask;
    endtask

    task automatic driveUnits3(input logic [0:2] mask);
        for (int i = 0; i < 3; i++) begin
            bus3.unit_rs_id[i]           = rs_id_a[i];
            bus3.unit_result_reg_addr[i] = addr_a[i];
            bus3.unit_result[i]          = val_a[i];
            bus3.unit_cr0_xer[i]         = flags_a[i];
        end
        bus3.unit_valid = mask;
    endtask

    // One cycle on the 4-unit bus: present mask, expect a grant, queue the broadcast.
    task automatic applyStimulus(input logic [0:3] mask, input int exp_grant);
        logic [0:3] exp_ready;
        exp_t e;
        driveUnits4(mask);
        @(negedge clk);
        exp_ready = '0;
        if (exp_grant >= 0) begin
            exp_ready[exp_grant] = 1'b1;
            e.rs_id = rs_id_a[exp_grant];
            e.addr  = addr_a[exp_grant];
            e.value = val_a[exp_grant];
            e.flags = flags_a[exp_grant];
            q4.push_back(e);
        end
        checkOutput("bus4 grant", 64'(bus4.unit_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus3(input logic [0:2] mask, input int exp_grant);
        logic [0:2] exp_ready;
        exp_t e;
        driveUnits3(mask);
        @(negedge clk);
        exp_ready = '0;
        if (exp_grant >= 0) begin
            exp_ready[exp_grant] = 1'b1;
            e.rs_id = rs_id_a[exp_grant];
            e.addr  = addr_a[exp_grant];
            e.value = val_a[exp_grant];
            e.flags = flags_a[exp_grant];
            q3.push_back(e);
        end
        checkOutput("bus3 grant", 64'(bus3.unit_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every broadcast must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (!rst && bus4.update_valid) begin
            if (q4.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL bus4 unexpected broadcast: got value 0x%0h, expected no broadcast", bus4.update_value);
            end else begin
                e = q4.pop_front();
                act = {bus4.update_rs_id, bus4.update_result_reg_addr, bus4.update_value, bus4.update_cr0_xer};
                checkOutput("bus4 broadcast", 64'(act), 64'(e));
            end
        end
        if (!rst && bus3.update_valid) begin
            if (q3.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL bus3 unexpected broadcast: got value 0x%0h, expected no broadcast", bus3.update_value);
            end else begin
                e = q3.pop_front();
                act = {bus3.update_rs_id, bus3.update_result_reg_addr, bus3.update_value, bus3.update_cr0_xer};
                checkOutput("bus3 broadcast", 64'(act), 64'(e));
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rs_id_a[i] = RSW'(i * 3 + 1);
            addr_a[i]  = 5'(i + 20);
            val_a[i]   = 32'hA000_0000 + 32'(i);
            flags_a[i] = cond_exception_t'(7'(i * 5 + 3));
        end
        rst = 1'b0;
        driveUnits4(4'b0000);
        driveUnits3(3'b000);
        #1 rst = 1'b1;
        driveUnits4(4'b1111);
        #2;
        checkOutput("reset ready", 64'(bus4.unit_ready), 64'd0);
        checkOutput("reset update_valid", 64'(bus4.update_valid), 64'd0);
        checkOutput("reset update_value", 64'(bus4.update_value), 64'd0);
        checkOutput("reset update_rs_id", 64'(bus4.update_rs_id), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("reset ready after edge", 64'(bus4.unit_ready), 64'd0);
        rst = 1'b0;

        // Round-robin with everything valid, then drain the pending units.
        applyStimulus(4'b1111, 0);
        applyStimulus(4'b1111, 1);
        applyStimulus(4'b1111, 2);
        applyStimulus(4'b1111, 3);
        applyStimulus(4'b1111, 0);
        applyStimulus(4'b1111, 1);
        applyStimulus(4'b1011, 2);
        applyStimulus(4'b1001, 3);
        applyStimulus(4'b1000, 0);

        // Single unit back-to-back, pointer sitting at 1.
        val_a[2] = 32'h11;
        applyStimulus(4'b0010, 2);
        val_a[2] = 32'h22;
        applyStimulus(4'b0010, 2);
        val_a[2] = 32'h33;
        applyStimulus(4'b0010, 2);

        // Idle gap: valid pulses once, value and pointer hold.
        applyStimulus(4'b0000, -1);
        applyStimulus(4'b0000, -1);
        checkOutput("idle update_valid", 64'(bus4.update_valid), 64'd0);
        checkOutput("idle value hold", 64'(bus4.update_value), 64'h33);
        applyStimulus(4'b1101, 3);
        applyStimulus(4'b1100, 0);
        applyStimulus(4'b0100, 1);

        // Reset right after a transfer drops the pending broadcast.
        applyStimulus(4'b0011, 2);
        rst = 1'b1;
        #1;
        checkOutput("midop update_valid", 64'(bus4.update_valid), 64'd0);
        checkOutput("midop ready", 64'(bus4.unit_ready), 64'd0);
        dropped = q4.pop_front();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0011, 2);
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0000, -1);
        applyStimulus(4'b0000, -1);

        // Counter run from a fresh reset: 10 transfers, 4 conflict cycles.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b1100, 0);
        applyStimulus(4'b0100, 1);
        applyStimulus(4'b0011, 2);
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b1010, 0);
        applyStimulus(4'b0010, 2);
        applyStimulus(4'b0101, 3);
        applyStimulus(4'b0100, 1);
        applyStimulus(4'b1000, 0);
        applyStimulus(4'b0010, 2);
        applyStimulus(4'b0000, -1);
        applyStimulus(4'b0000, -1);
`ifdef RESULT_BUS_PERF_EN
        checkOutput("perf_broadcasts", 64'(perf_b4), 64'd10);
        checkOutput("perf_conflicts", 64'(perf_c4), 64'd4);
`endif

        // Three units: the pointer must wrap from 2 back to 0.
        applyStimulus3(3'b100, 0);
        applyStimulus3(3'b101, 2);
        applyStimulus3(3'b101, 0);
        val_a[2] = 32'h5555_0002;
        applyStimulus3(3'b101, 2);
        applyStimulus3(3'b100, 0);
        applyStimulus3(3'b000, -1);
        applyStimulus3(3'b000, -1);

        checkOutput("bus4 queue drained", 64'(q4.size()), 64'd0);
        checkOutput("bus3 queue drained", 64'(q3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
